// File: rtl/riscv_exec_alu.sv
// rtl/riscv_exec_alu.sv - execute-stage ALU with branch-condition logic and registered branch-target adder
//
// Purpose: 32-bit ALU (arithmetic, logic, shift, compare, branch condition)
// plus a PC-relative target adder, with results held in an output register stage.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-high reset
//   EN         in   stage enable; output registers load only when set
//   op1, op2   in   ALU operands A and B
//   alu_op     in   operation select
//   pc         in   PC of the instruction in execute
//   imm        in   sign-extended immediate
//   alu_result out  registered ALU result
//   bit_branch out  registered branch-taken flag
//   pc_jump    out  registered branch/jump target
//   valid      out  registered copy of EN

module riscv_exec_alu #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] alu_result,
  output logic            bit_branch,
  output logic [XLEN-1:0] pc_jump,
  output logic            valid
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_BEQ   = 4'd10,
    OP_BNE   = 4'd11,
    OP_BLT   = 4'd12,
    OP_BGE   = 4'd13,
    OP_PASSB = 4'd14,
    OP_NOP   = 4'd15
  } alu_op_e;

  logic [XLEN-1:0] r_alu_result;
  logic            r_bit_branch;
  logic [XLEN-1:0] r_pc_jump;
  logic            r_valid;

  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_diff;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_eq;
  logic [XLEN-1:0] w_alu;
  logic            w_branch;
  logic [XLEN-1:0] w_addend;
  logic [XLEN-1:0] w_target;
  logic            w_unused;

  // Only the low five bits of op2 act as a shift amount.
  assign w_shamt = op2[4:0];
  assign w_diff  = op1 - op2;
  assign w_lt_s  = $signed(op1) < $signed(op2);
  assign w_lt_u  = op1 < op2;
  assign w_eq    = (op1 == op2);

  always_comb begin
    w_alu    = '0;
    w_branch = 1'b0;
    case (alu_op_e'(alu_op))
      OP_ADD:   w_alu = op1 + op2;
      OP_SUB:   w_alu = w_diff;
      OP_AND:   w_alu = op1 & op2;
      OP_OR:    w_alu = op1 | op2;
      OP_XOR:   w_alu = op1 ^ op2;
      OP_SLL:   w_alu = op1 << w_shamt;
      OP_SRL:   w_alu = op1 >> w_shamt;
      OP_SRA:   w_alu = XLEN'($signed(op1) >>> w_shamt);
      OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, w_lt_s};
      OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, w_lt_u};
      // Branches still report op1-op2 on the result bus.
      OP_BEQ: begin
        w_alu    = w_diff;
        w_branch = w_eq;
      end
      OP_BNE: begin
        w_alu    = w_diff;
        w_branch = ~w_eq;
      end
      OP_BLT: begin
        w_alu    = w_diff;
        w_branch = w_lt_s;
      end
      OP_BGE: begin
        w_alu    = w_diff;
        w_branch = ~w_lt_s;
      end
      OP_PASSB: w_alu = op2;
      OP_NOP:   w_alu = '0;
      default:  w_alu = '0;
    endcase
  end

  // Target addend is imm << 1 with the sign bit kept in place; imm[30] drops out.
  assign w_addend = {imm[XLEN-1], imm[XLEN-3:0], 1'b0};
  assign w_target = pc + w_addend;
  assign w_unused = imm[XLEN-2];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_alu_result <= '0;
      r_bit_branch <= 1'b0;
      r_pc_jump    <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_valid <= EN;
      if (EN) begin
        r_alu_result <= w_alu;
        r_bit_branch <= w_branch;
        r_pc_jump    <= w_target;
      end
    end
  end

  assign alu_result = r_alu_result;
  assign bit_branch = r_bit_branch;
  assign pc_jump    = r_pc_jump;
  assign valid      = r_valid;

endmodule

// File: tb/tb_riscv_exec_alu.sv
// tb/tb_riscv_exec_alu.sv - self-checking bench for riscv_exec_alu with a behavioural reference model

module tb_riscv_exec_alu;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_op;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        bit_branch;
  logic [31:0] pc_jump;
  logic        valid;

  int n_checks;
  int n_fail;

  logic [31:0] e_res;
  logic        e_br;
  logic [31:0] e_pcj;
  logic        e_valid;

  riscv_exec_alu #(.XLEN(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .op1        (op1),
    .op2        (op2),
    .alu_op     (alu_op),
    .pc         (pc),
    .imm        (imm),
    .alu_result (alu_result),
    .bit_branch (bit_branch),
    .pc_jump    (pc_jump),
    .valid      (valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic br);
    int signed sa;
    int signed sb;
    int        amt;
    sa  = a;
    sb  = b;
    amt = b % 32;
    br  = 1'b0;
    r   = 32'd0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << amt;
      4'd6:  r = a >> amt;
      4'd7:  r = $unsigned(sa >>> amt);
      4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin r = a - b; br = (a == b); end
      4'd11: begin r = a - b; br = (a != b); end
      4'd12: begin r = a - b; br = (sa < sb); end
      4'd13: begin r = a - b; br = (sa >= sb); end
      4'd14: r = b;
      default: r = 32'd0;
    endcase
  endfunction

  // Target = pc + 2*imm, with bit 31 of the addend forced to imm's sign bit.
  function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [31:0] i);
    logic [31:0] addend;
    addend = ((i * 2) & 32'h7FFF_FFFF) | (i & 32'h8000_0000);
    return p + addend;
  endfunction

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] i, input logic en);
    logic [31:0] r;
    logic        br;
    alu_op = op;
    op1    = a;
    op2    = b;
    pc     = p;
    imm    = i;
    EN     = en;
    if (en) begin
      ref_alu(op, a, b, r, br);
      e_res = r;
      e_br  = br;
      e_pcj = ref_target(p, i);
    end
    e_valid = en;
    @(posedge CLK);
    #1;
    check("alu_result", alu_result, e_res);
    check("bit_branch", {31'd0, bit_branch}, {31'd0, e_br});
    check("pc_jump", pc_jump, e_pcj);
    check("valid", {31'd0, valid}, {31'd0, e_valid});
  endtask

  // Directed case with hand-computed constants from the operation table.
  task automatic dir(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input logic exp_b);
    step(op, a, b, 32'h100, 32'h8, 1'b1);
    check(tag, alu_result, exp_r);
    check({tag, "_br"}, {31'd0, bit_branch}, {31'd0, exp_b});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST    = 1'b0;
    EN     = 1'b0;
    op1    = 32'd0;
    op2    = 32'd0;
    alu_op = 4'd0;
    pc     = 32'd0;
    imm    = 32'd0;
    e_res = 0; e_br = 0; e_pcj = 0; e_valid = 0;

    // Asynchronous reset asserted between edges.
    #2;
    RST = 1'b1;
    #1;
    check("rst_res", alu_result, 32'd0);
    check("rst_br", {31'd0, bit_branch}, 32'd0);
    check("rst_pcj", pc_jump, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    EN = 1'b1; op1 = 32'd5; op2 = 32'd3;
    @(posedge CLK); #1;
    check("rst_dom_valid", {31'd0, valid}, 32'd0);
    check("rst_dom_res", alu_result, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    dir("add_5_3",    4'd0,  32'd5,         32'd3,         32'd8,         1'b0);
    check("first_valid", {31'd0, valid}, 32'd1);
    dir("add_wrap",   4'd0,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    dir("sub_wrap",   4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0);
    dir("slt",        4'd8,  32'h8000_0000, 32'd1,         32'd1,         1'b0);
    dir("sltu",       4'd9,  32'h8000_0000, 32'd1,         32'd0,         1'b0);
    dir("sra",        4'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0);
    dir("srl",        4'd6,  32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0);
    dir("sll",        4'd5,  32'd1,         32'd31,        32'h8000_0000, 1'b0);
    dir("beq",        4'd10, 32'd7,         32'd7,         32'd0,         1'b1);
    dir("bne",        4'd11, 32'd7,         32'd7,         32'd0,         1'b0);
    dir("blt",        4'd12, 32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b1);
    dir("bge",        4'd13, 32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    dir("add_nobr",   4'd0,  32'd7,         32'd7,         32'd14,        1'b0);
    dir("passb",      4'd14, 32'd1,         32'h1234_5000, 32'h1234_5000, 1'b0);
    dir("nop",        4'd15, 32'hDEAD,      32'hBEEF,      32'd0,         1'b0);

    // Branch target.
    step(4'd0, 32'd0, 32'd0, 32'h100, 32'h8, 1'b1);
    check("tgt_pos", pc_jump, 32'h110);
    step(4'd0, 32'd0, 32'd0, 32'h100, 32'hFFFF_FFFC, 1'b1);
    check("tgt_neg", pc_jump, 32'h0000_00F8);
    step(4'd0, 32'd0, 32'd0, 32'h0, 32'h4000_0001, 1'b1);
    check("tgt_bit30", pc_jump, 32'h0000_0002);

    // Hold then re-enable.
    step(4'd0, 32'd10, 32'd20, 32'h200, 32'h10, 1'b1);
    step(4'd1, 32'd99, 32'd1, 32'h300, 32'h20, 1'b0);
    check("hold_res", alu_result, 32'd30);
    check("hold_pcj", pc_jump, 32'h220);
    check("hold_valid", {31'd0, valid}, 32'd0);
    step(4'd1, 32'd99, 32'd1, 32'h300, 32'h20, 1'b1);
    check("reen_res", alu_result, 32'd98);

    // Reset mid-operation discards the in-flight result.
    alu_op = 4'd0; op1 = 32'd1; op2 = 32'd2; EN = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_res", alu_result, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    e_res = 0; e_br = 0; e_pcj = 0;
    step(4'd0, 32'd40, 32'd2, 32'h10, 32'h1, 1'b1);
    check("post_rst", alu_result, 32'd42);

    // Randomized sweep against the model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) b = {a[31:5] ^ 27'h5A5A5A5, 5'(b)};
      step(4'($urandom_range(0, 15)), a, b, $urandom, $urandom, ($urandom_range(0, 4) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
